// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the datapath bus controller: FSM encoding,
// source/destination indices and default sizing.
package bus_ctrl_pkg;

  localparam int P_NUM_SRC  = 7;
  localparam int P_NUM_DST  = 10;
  localparam int P_MAX_HOLD = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int SRC_ALU    = 0;
  localparam int SRC_RAM    = 1;
  localparam int SRC_IO     = 2;
  localparam int SRC_REGS   = 3;
  localparam int SRC_PC     = 4;
  localparam int SRC_FLAGS  = 5;
  localparam int SRC_OFFSET = 6;

  localparam int DST_RAM    = 0;
  localparam int DST_IO     = 1;
  localparam int DST_REGS   = 2;
  localparam int DST_PC     = 3;
  localparam int DST_FLAGS  = 4;
  localparam int DST_MA     = 5;
  localparam int DST_IOA    = 6;
  localparam int DST_T1     = 7;
  localparam int DST_T2     = 8;
  localparam int DST_IR     = 9;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the requesting units and the bus arbiter.
interface bus_arbiter_if
  import bus_ctrl_pkg::*;
#(
  parameter int p_num_src = P_NUM_SRC,
  parameter int p_num_dst = P_NUM_DST
);
  logic [p_num_src-1:0]           i_w_req;
  logic [p_num_src-1:0]           i_w_lock;
  logic [p_num_src*p_num_dst-1:0] i_w_dst_sel;
  logic [p_num_src-1:0]           o_w_gnt;
  logic [p_num_dst-1:0]           o_w_ld_en;
  logic                           o_w_busy;
  logic                           o_w_timeout;

  modport master (
    output i_w_req, i_w_lock, i_w_dst_sel,
    input  o_w_gnt, o_w_ld_en, o_w_busy, o_w_timeout
  );

  modport slave (
    input  i_w_req, i_w_lock, i_w_dst_sel,
    output o_w_gnt, o_w_ld_en, o_w_busy, o_w_timeout
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after ptr (wrapping),
// with an exclusion mask applied before the search.
module rr_priority_picker #(
  parameter  int p_num = 7,
  localparam int IW    = (p_num > 1) ? $clog2(p_num) : 1
) (
  input  logic [p_num-1:0] req,
  input  logic [p_num-1:0] excl,
  input  logic [IW-1:0]    ptr,
  output logic [p_num-1:0] win,
  output logic             vld,
  output logic [IW-1:0]    idx
);

  logic [p_num-1:0] cand;
  logic [IW-1:0]    k;
  int               pos;

  assign cand = req & ~excl;

  always_comb begin
    win = '0;
    vld = 1'b0;
    idx = '0;
    k   = '0;
    pos = 0;
    for (int i = 0; i < p_num; i++) begin
      pos = int'(ptr) + i;
      if (pos >= p_num) pos = pos - p_num;
      k = IW'(pos);
      if (!vld && cand[k]) begin
        vld    = 1'b1;
        win[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Single owner of the OR-combined datapath bus: round-robin grant with bounded
// lock, registered one-hot grant and per-destination load enables.
module bus_arbiter
  import bus_ctrl_pkg::*;
#(
  parameter int p_num_src  = P_NUM_SRC,
  parameter int p_num_dst  = P_NUM_DST,
  parameter int p_max_hold = P_MAX_HOLD
) (
  input logic          i_w_clk,
  input logic          i_w_rst_n,
  bus_arbiter_if.slave bus
);

  localparam int IW = (p_num_src > 1) ? $clog2(p_num_src) : 1;
  localparam int CW = $clog2(p_max_hold + 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [p_num_src-1:0] gnt_q, gnt_d;
  logic [p_num_dst-1:0] ld_en_q, ld_en_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;

  logic                 hold_ok, expire;
  logic [p_num_src-1:0] excl;
  logic [p_num_src-1:0] pick_win;
  logic                 pick_vld;
  logic [IW-1:0]        pick_idx;

  // A lock only counts for the current owner, and only while it still requests.
  assign hold_ok = (state_q != ST_IDLE) && bus.i_w_req[owner_q] && bus.i_w_lock[owner_q];
  assign expire  = hold_ok && (cnt_q == CW'(p_max_hold - 1));

  always_comb begin
    excl = '0;
    if (expire) excl[owner_q] = 1'b1;
  end

  rr_priority_picker #(.p_num(p_num_src)) u_pick (
    .req  (bus.i_w_req),
    .excl (excl),
    .ptr  (ptr_q),
    .win  (pick_win),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d   = ST_IDLE;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = '0;
    gnt_d     = '0;
    timeout_d = expire;
    if (hold_ok && !expire) begin
      state_d = ST_HOLD;
      cnt_d   = cnt_q + CW'(1);
      gnt_d   = gnt_q;
    end else if (pick_vld) begin
      state_d = ST_GRANT;
      owner_d = pick_idx;
      gnt_d   = pick_win;
      ptr_d   = (pick_idx == IW'(p_num_src - 1)) ? '0 : pick_idx + IW'(1);
    end
  end

  // Load enables follow the grant; an empty grant selects no slice.
  always_comb begin
    ld_en_d = '0;
    for (int s = 0; s < p_num_src; s++) begin
      if (gnt_d[s]) ld_en_d = bus.i_w_dst_sel[s*p_num_dst +: p_num_dst];
    end
    busy_d = |gnt_d;
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      ld_en_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      ld_en_q   <= ld_en_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_w_gnt     = gnt_q;
  assign bus.o_w_ld_en   = ld_en_q;
  assign bus.o_w_busy    = busy_q;
  assign bus.o_w_timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks of bus_arbiter with a short lock limit.
module tb_bus_arbiter;
  import bus_ctrl_pkg::*;

  localparam int NS = 7;
  localparam int ND = 10;
  localparam int MH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if #(.p_num_src(NS), .p_num_dst(ND)) bif ();

  bus_arbiter #(.p_num_src(NS), .p_num_dst(ND), .p_max_hold(MH)) dut (
    .i_w_clk   (clk),
    .i_w_rst_n (rst_n),
    .bus       (bif)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ND-1:0] mask_of(input int s);
    return ND'((s + 1) * 37);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int s, input logic [ND-1:0] m);
    bif.i_w_dst_sel[s*ND +: ND] = m;
  endtask

  task automatic chk_out(input string tag, input logic [NS-1:0] g, input logic [ND-1:0] l,
                         input logic t);
    chk({tag, ".gnt"},  32'(bif.o_w_gnt),     32'(g));
    chk({tag, ".ld"},   32'(bif.o_w_ld_en),   32'(l));
    chk({tag, ".busy"}, 32'(bif.o_w_busy),    32'(|g));
    chk({tag, ".to"},   32'(bif.o_w_timeout), 32'(t));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bif.i_w_req  = '0;
    bif.i_w_lock = '0;
    #2;
    rst_n = 1'b1;
  endtask

  logic [NS-1:0]    prev_req;
  logic [NS*ND-1:0] prev_sel;
  logic [ND-1:0]    exp_ld;

  initial begin
    bif.i_w_req     = '0;
    bif.i_w_lock    = '0;
    bif.i_w_dst_sel = '0;
    for (int s = 0; s < NS; s++) set_sel(s, mask_of(s));

    // reset state
    step();
    chk_out("reset", '0, '0, 1'b0);
    rst_n = 1'b1;

    // single request, one-cycle grant
    set_sel(SRC_IO, 10'b0010000000);
    bif.i_w_req = 7'b0000100;
    step();
    chk_out("single", 7'b0000100, 10'b0010000000, 1'b0);
    bif.i_w_req = '0;
    step();
    chk_out("single_rel", '0, '0, 1'b0);
    set_sel(SRC_IO, mask_of(SRC_IO));

    // round robin, back-to-back, wrap to 0
    do_reset();
    bif.i_w_req = '1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_out($sformatf("rr%0d", i), NS'(1) << (i % NS), mask_of(i % NS), 1'b0);
    end
    bif.i_w_req = '0;
    step();
    chk_out("rr_idle", '0, '0, 1'b0);

    // lock held for MH cycles, then forced hand-off to src3
    do_reset();
    bif.i_w_req  = 7'b0001010;
    bif.i_w_lock = 7'b0000010;
    for (int i = 0; i < MH; i++) begin
      step();
      chk_out($sformatf("lock%0d", i), 7'b0000010, mask_of(1), 1'b0);
    end
    step();
    chk_out("lock_to", 7'b0001000, mask_of(3), 1'b1);
    step();
    chk_out("lock_after", 7'b0000010, mask_of(1), 1'b0);

    // timeout with no competitor: one idle cycle then src1 again
    do_reset();
    bif.i_w_req  = 7'b0000010;
    bif.i_w_lock = 7'b0000010;
    for (int i = 0; i < MH; i++) begin
      step();
      chk_out($sformatf("solo%0d", i), 7'b0000010, mask_of(1), 1'b0);
    end
    step();
    chk_out("solo_to", '0, '0, 1'b1);
    step();
    chk_out("solo_regrant", 7'b0000010, mask_of(1), 1'b0);

    // withdraw while locked
    do_reset();
    bif.i_w_req  = 7'b0100000;
    bif.i_w_lock = 7'b0100000;
    step();
    chk_out("wd_gnt", 7'b0100000, mask_of(5), 1'b0);
    step();
    chk_out("wd_hold", 7'b0100000, mask_of(5), 1'b0);
    bif.i_w_req = '0;
    step();
    chk_out("wd_drop", '0, '0, 1'b0);
    bif.i_w_req = 7'b0100000;
    step();
    chk_out("wd_gnt2", 7'b0100000, mask_of(5), 1'b0);
    bif.i_w_req = 7'b0000001;
    step();
    chk_out("wd_next", 7'b0000001, mask_of(0), 1'b0);

    // lock from a non-owner is ignored until it owns the bus
    do_reset();
    bif.i_w_req  = 7'b0000101;
    bif.i_w_lock = 7'b0000100;
    step();
    chk_out("nolock0", 7'b0000001, mask_of(0), 1'b0);
    step();
    chk_out("nolock1", 7'b0000100, mask_of(2), 1'b0);
    step();
    chk_out("nolock2", 7'b0000100, mask_of(2), 1'b0);

    // zero destination mask: drive without load
    do_reset();
    set_sel(SRC_PC, '0);
    bif.i_w_req = 7'b0010000;
    step();
    chk_out("zmask", 7'b0010000, '0, 1'b0);
    set_sel(SRC_PC, mask_of(SRC_PC));

    // asynchronous reset in the middle of a hold
    do_reset();
    bif.i_w_req  = 7'b0000010;
    bif.i_w_lock = 7'b0000010;
    step();
    step();
    chk_out("pre_rst", 7'b0000010, mask_of(1), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async", '0, '0, 1'b0);
    bif.i_w_req  = '1;
    bif.i_w_lock = '0;
    step();
    chk_out("rst_held", '0, '0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("rst_ptr0", 7'b0000001, mask_of(0), 1'b0);

    // random traffic: structural invariants and load-enable source
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      bif.i_w_req     = NS'($urandom);
      bif.i_w_lock    = NS'($urandom);
      bif.i_w_dst_sel = (NS*ND)'({$urandom, $urandom, $urandom});
      prev_req = bif.i_w_req;
      prev_sel = bif.i_w_dst_sel;
      step();
      exp_ld = '0;
      for (int s = 0; s < NS; s++)
        if (bif.o_w_gnt[s]) exp_ld = prev_sel[s*ND +: ND];
      chk("inv_1hot", 32'(bif.o_w_gnt & (bif.o_w_gnt - NS'(1))), 32'd0);
      chk("inv_req",  32'(bif.o_w_gnt & ~prev_req), 32'd0);
      chk("inv_ld",   32'(bif.o_w_ld_en), 32'(exp_ld));
      chk("inv_busy", 32'(bif.o_w_busy), 32'(|bif.o_w_gnt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
